// File: rtl/adc0832_responder.sv
// ADC0832 slave emulator: decodes the serial mux command from a master
// and answers with an 8-bit value MSB-first then LSB-first on DO.
module adc0832_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SEL_PIN_PORT,
    input  logic       ADC_CLK_PORT,
    input  logic       ADC_COMMAND_DATA_PORT,
    input  logic [7:0] CH0_VALUE,
    input  logic [7:0] CH1_VALUE,
    output logic       ADC_READ_PORT,
    output logic       DO_EN,
    output logic       BUSY,
    output logic       CONV_DONE,
    output logic [1:0] MUX_CFG
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        GET_SGL,
        GET_ODD,
        NULL_BIT,
        MSB_OUT,
        LSB_OUT,
        HOLD
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic sclk_q;
    logic cs_s;
    logic sclk_s;
    logic di_s;
    logic rise;
    logic fall;

    logic [7:0] data_q;
    logic [3:0] cnt;
    logic       sgl_q;
    logic       armed;
    logic       do_q;
    logic       en_q;
    logic       busy_q;
    logic       done_q;
    logic [1:0] mux_q;

    logic [8:0] diff;
    logic [7:0] sel_byte;

    // Synchronizers run freely so they are already settled when reset drops
    always_ff @(posedge clk) begin
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SEL_PIN_PORT};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_CLK_PORT};
        di_sync   <= {di_sync[SYNC_STAGES-2:0], ADC_COMMAND_DATA_PORT};
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign di_s   = di_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;
    assign fall   = ~sclk_s & sclk_q;

    always_comb begin
        diff     = '0;
        sel_byte = '0;
        case ({sgl_q, di_s})
            2'b10: sel_byte = CH0_VALUE;
            2'b11: sel_byte = CH1_VALUE;
            2'b00: begin
                diff     = {1'b0, CH0_VALUE} - {1'b0, CH1_VALUE};
                sel_byte = diff[8] ? 8'h00 : diff[7:0];
            end
            default: begin
                diff     = {1'b0, CH1_VALUE} - {1'b0, CH0_VALUE};
                sel_byte = diff[8] ? 8'h00 : diff[7:0];
            end
        endcase
    end

    // armed stays low after reset until CS has been seen high once
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            do_q   <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mux_q  <= 2'b00;
            data_q <= 8'h00;
            sgl_q  <= 1'b0;
            cnt    <= 4'd0;
            armed  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cs_s) begin
                state  <= IDLE;
                do_q   <= 1'b0;
                en_q   <= 1'b0;
                busy_q <= 1'b0;
                armed  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (armed) state <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (rise && di_s) begin
                            busy_q <= 1'b1;
                            state  <= GET_SGL;
                        end
                    end
                    GET_SGL: begin
                        if (rise) begin
                            sgl_q <= di_s;
                            state <= GET_ODD;
                        end
                    end
                    GET_ODD: begin
                        if (rise) begin
                            mux_q  <= {sgl_q, di_s};
                            data_q <= sel_byte;
                            state  <= NULL_BIT;
                        end
                    end
                    NULL_BIT: begin
                        if (fall) begin
                            en_q  <= 1'b1;
                            do_q  <= 1'b0;
                            cnt   <= 4'd7;
                            state <= MSB_OUT;
                        end
                    end
                    MSB_OUT: begin
                        if (fall) begin
                            do_q <= data_q[cnt[2:0]];
                            if (cnt == 4'd0) begin
                                cnt   <= 4'd1;
                                state <= LSB_OUT;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                    end
                    LSB_OUT: begin
                        if (fall) begin
                            if (cnt == 4'd8) begin
                                do_q   <= 1'b0;
                                en_q   <= 1'b0;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= HOLD;
                            end else begin
                                do_q <= data_q[cnt[2:0]];
                                cnt  <= cnt + 4'd1;
                            end
                        end
                    end
                    HOLD: begin
                        state <= HOLD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ADC_READ_PORT = do_q;
    assign DO_EN         = en_q;
    assign BUSY          = busy_q;
    assign CONV_DONE     = done_q;
    assign MUX_CFG       = mux_q;

endmodule

// File: tb/tb_adc0832_responder.sv
// Bench for adc0832_responder: acts as the serial master and compares
// the returned bit stream with a value computed from the channel rules.
module tb_adc0832_responder;

    localparam int SS   = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       SEL_PIN_PORT;
    logic       ADC_CLK_PORT;
    logic       ADC_COMMAND_DATA_PORT;
    logic [7:0] CH0_VALUE;
    logic [7:0] CH1_VALUE;
    logic       ADC_READ_PORT;
    logic       DO_EN;
    logic       BUSY;
    logic       CONV_DONE;
    logic [1:0] MUX_CFG;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int viol = 0;
    int since = 1000;
    logic prev_do = 1'b0;
    logic prev_sclk = 1'b0;

    adc0832_responder #(.SYNC_STAGES(SS)) dut (
        .clk                  (clk),
        .reset                (reset),
        .SEL_PIN_PORT         (SEL_PIN_PORT),
        .ADC_CLK_PORT         (ADC_CLK_PORT),
        .ADC_COMMAND_DATA_PORT(ADC_COMMAND_DATA_PORT),
        .CH0_VALUE            (CH0_VALUE),
        .CH1_VALUE            (CH1_VALUE),
        .ADC_READ_PORT        (ADC_READ_PORT),
        .DO_EN                (DO_EN),
        .BUSY                 (BUSY),
        .CONV_DONE            (CONV_DONE),
        .MUX_CFG              (MUX_CFG)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (CONV_DONE === 1'b1) done_cnt++;
    end

    // DO may only move shortly after a serial-clock falling edge
    always @(negedge clk) begin
        if (prev_sclk && !ADC_CLK_PORT) since = 0;
        else if (since < 1000) since++;
        if (ADC_READ_PORT !== prev_do && !reset && !SEL_PIN_PORT
            && since > SS + 2)
            viol++;
        prev_do   = ADC_READ_PORT;
        prev_sclk = ADC_CLK_PORT;
    end

    function automatic logic [7:0] model_byte(input logic [7:0] c0,
                                              input logic [7:0] c1,
                                              input logic sgl,
                                              input logic odd);
        int d;
        if (sgl) d = odd ? int'(c1) : int'(c0);
        else     d = odd ? int'(c1) - int'(c0) : int'(c0) - int'(c1);
        if (d < 0) d = 0;
        return d[7:0];
    endfunction

    function automatic logic [15:0] model_stream(input logic [7:0] b);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[14-i] = b[7-i];
        for (int j = 1; j < 8; j++) s[7-j] = b[j];
        return s;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic di, output logic sampled);
        ADC_COMMAND_DATA_PORT = di;
        wait_clk(HALF);
        sampled = ADC_READ_PORT;
        ADC_CLK_PORT = 1'b1;
        wait_clk(HALF);
        ADC_CLK_PORT = 1'b0;
    endtask

    task automatic xfer(input int lead, input logic sgl, input logic odd,
                        input int abort_at, input int snap_at,
                        input logic [7:0] snap_val,
                        output logic [15:0] got, output logic en_seen,
                        output logic busy_seen);
        logic s;
        got = '0;
        en_seen = 1'b0;
        busy_seen = 1'b0;
        SEL_PIN_PORT = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < lead; i++) pulse(1'b0, s);
        pulse(1'b1, s);
        pulse(sgl, s);
        pulse(odd, s);
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                SEL_PIN_PORT = 1'b1;
                return;
            end
            if (i == snap_at) CH0_VALUE = snap_val;
            pulse(1'b0, s);
            got[15-i] = s;
            if (i == 0) begin
                en_seen = DO_EN;
                busy_seen = BUSY;
            end
        end
        wait_clk(HALF);
    endtask

    task automatic end_cs();
        SEL_PIN_PORT = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic full_check(input string name, input logic [7:0] c0,
                              input logic [7:0] c1, input logic sgl,
                              input logic odd, input int lead);
        logic [15:0] got;
        logic [15:0] exp;
        logic en_s, busy_s;
        int d0;
        CH0_VALUE = c0;
        CH1_VALUE = c1;
        d0 = done_cnt;
        exp = model_stream(model_byte(c0, c1, sgl, odd));
        xfer(lead, sgl, odd, -1, -1, 8'h00, got, en_s, busy_s);
        total++;
        if (got !== exp)
            $display("FAIL %s stream got=%h exp=%h", name, got, exp);
        else passed++;
        total++;
        if (MUX_CFG !== {sgl, odd})
            $display("FAIL %s mux got=%b exp=%b", name, MUX_CFG, {sgl, odd});
        else passed++;
        total++;
        if (done_cnt - d0 !== 1 || DO_EN !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL %s end done=%0d en=%b busy=%b exp 1/0/0",
                     name, done_cnt - d0, DO_EN, BUSY);
        else passed++;
        total++;
        if (en_s !== 1'b1 || busy_s !== 1'b1)
            $display("FAIL %s active en=%b busy=%b exp 1/1",
                     name, en_s, busy_s);
        else passed++;
        end_cs();
    endtask

    task automatic test_reset();
        total++;
        if ({ADC_READ_PORT, DO_EN, BUSY, CONV_DONE, MUX_CFG} !== 6'b0)
            $display("FAIL reset outs got=%b exp=000000",
                     {ADC_READ_PORT, DO_EN, BUSY, CONV_DONE, MUX_CFG});
        else passed++;
    endtask

    task automatic test_single_ended();
        full_check("single_a5", 8'hA5, 8'h3C, 1'b1, 1'b0, 0);
    endtask

    task automatic test_differential();
        full_check("diff_odd1", 8'h30, 8'h50, 1'b0, 1'b1, 0);
        full_check("diff_sat", 8'h30, 8'h50, 1'b0, 1'b0, 0);
    endtask

    task automatic test_leading_zeros();
        full_check("lead_zero", 8'h12, 8'hFF, 1'b1, 1'b1, 3);
    endtask

    task automatic test_abort();
        logic [15:0] got;
        logic en_s, busy_s;
        int d0;
        CH0_VALUE = 8'h5A;
        d0 = done_cnt;
        xfer(0, 1'b1, 1'b0, 5, -1, 8'h00, got, en_s, busy_s);
        repeat (SS + 1) @(posedge clk);
        #1;
        total++;
        if (DO_EN !== 1'b0 || BUSY !== 1'b0 || ADC_READ_PORT !== 1'b0)
            $display("FAIL abort outs en=%b busy=%b do=%b exp 0/0/0",
                     DO_EN, BUSY, ADC_READ_PORT);
        else passed++;
        ADC_CLK_PORT = 1'b0;
        wait_clk(4 * HALF);
        total++;
        if (done_cnt !== d0)
            $display("FAIL abort done got=%0d exp=%0d", done_cnt, d0);
        else passed++;
        full_check("after_abort", 8'hC3, 8'h01, 1'b1, 1'b0, 1);
    endtask

    task automatic test_snapshot();
        logic [15:0] got;
        logic en_s, busy_s;
        CH0_VALUE = 8'h11;
        CH1_VALUE = 8'h00;
        xfer(0, 1'b1, 1'b0, -1, 3, 8'hEE, got, en_s, busy_s);
        total++;
        if (got !== model_stream(8'h11))
            $display("FAIL snapshot got=%h exp=%h", got, model_stream(8'h11));
        else passed++;
        end_cs();
    endtask

    task automatic test_reset_mid();
        logic s;
        CH0_VALUE = 8'h77;
        SEL_PIN_PORT = 1'b0;
        wait_clk(HALF);
        pulse(1'b1, s);
        pulse(1'b1, s);
        pulse(1'b0, s);
        pulse(1'b0, s);
        pulse(1'b0, s);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({ADC_READ_PORT, DO_EN, BUSY, CONV_DONE, MUX_CFG} !== 6'b0)
            $display("FAIL reset_mid outs got=%b exp=000000",
                     {ADC_READ_PORT, DO_EN, BUSY, CONV_DONE, MUX_CFG});
        else passed++;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(HALF);
        pulse(1'b1, s);
        pulse(1'b1, s);
        pulse(1'b0, s);
        pulse(1'b0, s);
        pulse(1'b0, s);
        total++;
        if (BUSY !== 1'b0 || DO_EN !== 1'b0 || MUX_CFG !== 2'b00)
            $display("FAIL reset_idle busy=%b en=%b mux=%b exp 0/0/00",
                     BUSY, DO_EN, MUX_CFG);
        else passed++;
        end_cs();
        full_check("after_reset", 8'h77, 8'h10, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            full_check("random", 8'($urandom), 8'($urandom),
                       1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_do_timing();
        total++;
        if (viol !== 0)
            $display("FAIL do_timing late changes got=%0d exp=0", viol);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        SEL_PIN_PORT = 1'b1;
        ADC_CLK_PORT = 1'b0;
        ADC_COMMAND_DATA_PORT = 1'b0;
        CH0_VALUE = 8'h00;
        CH1_VALUE = 8'h00;
        wait_clk(5);
        test_reset();
        reset = 1'b0;
        wait_clk(HALF);
        test_single_ended();
        test_differential();
        test_leading_zeros();
        test_abort();
        test_snapshot();
        test_reset_mid();
        test_random();
        test_do_timing();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc0832_responder.md
ADC0832_RESPONDER -- requirements
Module: adc0832_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each serial input (minimum 2).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port SEL_PIN_PORT, input, 1, chip select from the master, active low.
REQ-005 SHALL have port ADC_CLK_PORT, input, 1, serial clock from the master.
REQ-006 SHALL have port ADC_COMMAND_DATA_PORT, input, 1, serial command bits (DI) from the master.
REQ-007 SHALL have port CH0_VALUE, input, 8, emulated conversion value for channel 0.
REQ-008 SHALL have port CH1_VALUE, input, 8, emulated conversion value for channel 1.
REQ-009 SHALL have port ADC_READ_PORT, output, 1, serial data (DO) to the master.
REQ-010 SHALL have port DO_EN, output, 1, DO drive enable; 0 means the pad is tri-stated.
REQ-011 SHALL have port BUSY, output, 1, high from the start bit until DONE.
REQ-012 SHALL have port CONV_DONE, output, 1, one-clk pulse when the last data bit has been shifted out.
REQ-013 SHALL have port MUX_CFG, output, 2, {SGL, ODD} of the last accepted command.

Function
REQ-014 SHALL pass SEL_PIN_PORT, ADC_CLK_PORT and ADC_COMMAND_DATA_PORT through SYNC_STAGES flops, then detect rising and falling edges of the synchronized serial clock with one extra register.
REQ-015 SHALL support master serial clock high and low phases of at least SYNC_STAGES+2 clk cycles each; behaviour is undefined for faster serial clocks.
REQ-016 SHALL implement states IDLE, WAIT_START, GET_SGL, GET_ODD, NULL_BIT, MSB_OUT, LSB_OUT, HOLD.
REQ-017 IDLE -> WAIT_START when synchronized CS is low.
REQ-018 WAIT_START: on a serial-clock rising edge with DI=1 -> GET_SGL and BUSY=1; with DI=0, stay in WAIT_START.
REQ-019 GET_SGL: sample DI on the rising edge into SGL -> GET_ODD.
REQ-020 GET_ODD: sample DI on the rising edge into ODD, update MUX_CFG, snapshot the selected data byte in the same clk -> NULL_BIT.
REQ-021 Data selection SHALL be as follows. SGL=1, ODD=0 gives CH0_VALUE. SGL=1, ODD=1 gives CH1_VALUE. SGL=0, ODD=0 gives CH0-CH1, saturated to 0 if negative. SGL=0, ODD=1 gives CH1-CH0, saturated to 0 if negative. Arithmetic is 9-bit and the result is clamped to 8 bits.
REQ-022 NULL_BIT: on the next falling edge set DO_EN=1 and DO=0 -> MSB_OUT.
REQ-023 MSB_OUT: on each of the next 8 falling edges drive D7..D0 in order; after D0 -> LSB_OUT.
REQ-024 LSB_OUT: on each of the next 7 falling edges drive D1..D7 in order (D0 is not repeated).
REQ-025 After D7 in LSB_OUT, the next falling edge SHALL set DO=0 and DO_EN=0, pulse CONV_DONE for one clk, set BUSY=0, and go to HOLD.
REQ-026 HOLD: ignore all serial clock edges; go to IDLE when CS is high.
REQ-027 Synchronized CS going high in any state SHALL force IDLE on the next clk with DO_EN=0, DO=0 and BUSY=0; no CONV_DONE is issued on an aborted transfer.
REQ-028 DO SHALL change only within SYNC_STAGES+2 clk cycles after an ADC_CLK_PORT falling edge, and never on a rising edge.
REQ-029 Changes to CH0_VALUE or CH1_VALUE after the snapshot (REQ-020) SHALL NOT affect the current transfer.
REQ-030 Serial clock edges while CS is high SHALL be ignored.

Reset
REQ-031 While reset=1, the state SHALL be IDLE, ADC_READ_PORT=0, DO_EN=0, BUSY=0, CONV_DONE=0, MUX_CFG=2'b00 and the snapshot register 0.
REQ-032 Reset asserted mid-transfer SHALL take effect on the next clk edge; after release the block waits in IDLE for CS to go high and then low again.

Verification
REQ-033 Single-ended read: CH0=0xA5, command 1,1,0 -> after the null bit, DO=10100101 then 0100101; CONV_DONE pulses once; MUX_CFG=2'b10.
REQ-034 Differential read: CH0=0x30, CH1=0x50, command 1,0,1 -> 0x20 MSB-first then LSB-first; the same command with ODD=0 -> 0x00 (saturated).
REQ-035 Leading zeros: DI=0 for 3 rising edges, then command 1,1,1 with CH1=0xFF -> the zeros are ignored and 0xFF is returned.
REQ-036 Abort: CS raised after 4 MSB bits -> DO_EN=0 within SYNC_STAGES+1 clk; no CONV_DONE; the next full transfer is correct.
REQ-037 Snapshot: CH0 changed from 0x11 to 0xEE during MSB_OUT -> the transfer returns 0x11.
REQ-038 Reset mid-transfer -> all outputs at reset values on the next clk; the block stays idle until CS toggles high then low.
